// File: rtl/bch_encoder_core.sv
// Systematic binary BCH encoder: streams message chunks through, then appends the LFSR parity.
// Also carries a blank-ECC (all-ones message parity) streamer and a message-position counter.
//   state  | meaning
//   S_IDLE | waiting for start, ready = 1
//   S_DATA | passing message chunks, updating remainder
//   S_ECC  | shifting remainder out as parity chunks
module bch_encoder_core #(
    parameter int                BITS      = 1,
    parameter int                DATA_BITS = 7,
    parameter int                ECC_BITS  = 8,
    parameter logic [ECC_BITS:0] GEN_POLY  = 9'h1D1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            ce,
    input  logic [BITS-1:0] data_in,
    output logic [BITS-1:0] data_out,
    output logic            data_bits,
    output logic            ecc_bits,
    output logic            first,
    output logic            last,
    output logic            ready,
    input  logic            blank_start,
    output logic [BITS-1:0] blank_xor,
    output logic            blank_first,
    output logic            blank_last,
    input  logic            cnt_first,
    output logic            cnt_valid,
    output logic            cnt_last
);

    localparam int DC   = DATA_BITS / BITS;
    localparam int EC   = ECC_BITS / BITS;
    localparam int CMAX = (DC > EC) ? DC : EC;
    localparam int CW   = $clog2(CMAX + 1);

    function automatic logic [ECC_BITS-1:0] lfsr_chunk(input logic [ECC_BITS-1:0] r_in,
                                                       input logic [BITS-1:0]     chunk);
        logic [ECC_BITS-1:0] r;
        logic                fb;
        r = r_in;
        for (int i = BITS - 1; i >= 0; i--) begin
            fb = r[ECC_BITS-1] ^ chunk[i];
            r  = (r << 1) ^ (fb ? GEN_POLY[ECC_BITS-1:0] : '0);
        end
        return r;
    endfunction

    function automatic logic [ECC_BITS-1:0] blank_calc();
        logic [ECC_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < DC; i++) begin
            r = lfsr_chunk(r, '1);
        end
        return r;
    endfunction

    // Parity of an erased (all-ones) message, fixed at elaboration
    localparam logic [ECC_BITS-1:0] BLANK = blank_calc();

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ECC} enc_state_t;

    enc_state_t          state;
    logic [ECC_BITS-1:0] rem;
    logic [CW-1:0]       chunk_cnt;
    logic [ECC_BITS-1:0] blank_sr;
    logic [CW-1:0]       blank_cnt;
    logic [CW-1:0]       pos_cnt;

    // chunk_cnt counts chunks still to emit in the current phase, terminal count 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rem       <= '0;
            chunk_cnt <= '0;
            data_out  <= '0;
            data_bits <= 1'b0;
            ecc_bits  <= 1'b0;
            first     <= 1'b0;
            last      <= 1'b0;
            ready     <= 1'b1;
        end else if (ce) begin
            first <= 1'b0;
            last  <= 1'b0;
            case (state)
                S_IDLE: begin
                    data_out  <= '0;
                    data_bits <= 1'b0;
                    ecc_bits  <= 1'b0;
                    if (start) begin
                        rem       <= lfsr_chunk('0, data_in);
                        data_out  <= data_in;
                        data_bits <= 1'b1;
                        first     <= 1'b1;
                        ready     <= 1'b0;
                        if (DC == 1) begin
                            state     <= S_ECC;
                            chunk_cnt <= CW'(EC);
                        end else begin
                            state     <= S_DATA;
                            chunk_cnt <= CW'(DC - 1);
                        end
                    end
                end
                S_DATA: begin
                    rem       <= lfsr_chunk(rem, data_in);
                    data_out  <= data_in;
                    data_bits <= 1'b1;
                    if (chunk_cnt == CW'(1)) begin
                        state     <= S_ECC;
                        chunk_cnt <= CW'(EC);
                    end else begin
                        chunk_cnt <= chunk_cnt - CW'(1);
                    end
                end
                S_ECC: begin
                    data_out  <= rem[ECC_BITS-1 -: BITS];
                    rem       <= rem << BITS;
                    data_bits <= 1'b0;
                    ecc_bits  <= 1'b1;
                    if (chunk_cnt == CW'(1)) begin
                        last  <= 1'b1;
                        ready <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        chunk_cnt <= chunk_cnt - CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_sr    <= '0;
            blank_cnt   <= '0;
            blank_xor   <= '0;
            blank_first <= 1'b0;
            blank_last  <= 1'b0;
        end else if (ce) begin
            if (blank_start) begin
                blank_xor   <= BLANK[ECC_BITS-1 -: BITS];
                blank_sr    <= BLANK << BITS;
                blank_first <= 1'b1;
                blank_last  <= (EC == 1);
                blank_cnt   <= CW'(EC - 1);
            end else if (blank_cnt != '0) begin
                blank_xor   <= blank_sr[ECC_BITS-1 -: BITS];
                blank_sr    <= blank_sr << BITS;
                blank_first <= 1'b0;
                blank_last  <= (blank_cnt == CW'(1));
                blank_cnt   <= blank_cnt - CW'(1);
            end else begin
                blank_xor   <= '0;
                blank_first <= 1'b0;
                blank_last  <= 1'b0;
            end
        end
    end

    // Position framing runs on every clock, independent of ce
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_cnt   <= '0;
            cnt_valid <= 1'b0;
            cnt_last  <= 1'b0;
        end else if (cnt_first) begin
            pos_cnt   <= CW'(DC - 1);
            cnt_valid <= 1'b1;
            cnt_last  <= (DC == 1);
        end else if (cnt_valid) begin
            if (pos_cnt == '0) begin
                cnt_valid <= 1'b0;
                cnt_last  <= 1'b0;
            end else begin
                pos_cnt  <= pos_cnt - CW'(1);
                cnt_last <= (pos_cnt == CW'(1));
            end
        end
    end

endmodule

// File: tb/tb_bch_encoder_core.sv
// Directed + randomized bench for bch_encoder_core (BCH(15,7) defaults, one bit per clock).
module tb_bch_encoder_core;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       ce;
    logic [0:0] data_in;
    logic [0:0] data_out;
    logic       data_bits;
    logic       ecc_bits;
    logic       first;
    logic       last;
    logic       ready;
    logic       blank_start;
    logic [0:0] blank_xor;
    logic       blank_first;
    logic       blank_last;
    logic       cnt_first;
    logic       cnt_valid;
    logic       cnt_last;

    int errors = 0;
    int checks = 0;

    bch_encoder_core dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ce(ce), .data_in(data_in),
        .data_out(data_out), .data_bits(data_bits), .ecc_bits(ecc_bits),
        .first(first), .last(last), .ready(ready),
        .blank_start(blank_start), .blank_xor(blank_xor),
        .blank_first(blank_first), .blank_last(blank_last),
        .cnt_first(cnt_first), .cnt_valid(cnt_valid), .cnt_last(cnt_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Parity as the remainder of m(x)*x^8 divided by g(x), by long division
    function automatic logic [7:0] ref_parity(input logic [6:0] msg);
        logic [14:0] v;
        logic [14:0] g;
        v = {msg, 8'h00};
        g = 15'h01D1;
        for (int i = 14; i >= 8; i--) begin
            if (v[i]) v = v ^ (g << (i - 8));
        end
        return v[7:0];
    endfunction

    function automatic logic [15:0] enc_obs();
        return {10'b0, data_out, data_bits, ecc_bits, first, last, ready};
    endfunction

    function automatic logic [15:0] blank_obs();
        return {13'b0, blank_xor, blank_first, blank_last};
    endfunction

    function automatic logic [15:0] all_obs();
        return {5'b0, data_out, data_bits, ecc_bits, first, last, ready,
                blank_xor, blank_first, blank_last, cnt_valid, cnt_last};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full codeword; gap_pct is the chance of a ce=0 cycle before each chunk after the first
    task automatic encode(input logic [6:0] msg, input logic [7:0] par, input int gap_pct);
        logic [14:0] word;
        logic [15:0] exp_v;
        word  = {msg, par};
        exp_v = '0;
        chk("ready_before_start", 16'(ready), 16'(1));
        for (int k = 0; k < 15; k++) begin
            if (k > 0 && $urandom_range(99) < gap_pct) begin
                ce      = 1'b0;
                start   = 1'($urandom_range(1));
                data_in = 1'($urandom_range(1));
                step();
                chk($sformatf("hold msg=%h k=%0d", msg, k), enc_obs(), exp_v);
            end
            ce      = 1'b1;
            start   = (k == 0) ? 1'b1 : 1'($urandom_range(1));
            data_in = (k < 7) ? word[14-k] : 1'($urandom_range(1));
            step();
            exp_v = 16'({word[14-k], k < 7, k >= 7, k == 0, k == 14, k == 14});
            chk($sformatf("enc msg=%h k=%0d", msg, k), enc_obs(), exp_v);
        end
        start = 1'b0;
    endtask

    task automatic blank_run(input int restart_at);
        logic [7:0]  bl;
        logic [15:0] ev;
        int          j;
        bit          restarted;
        bl          = ref_parity(7'h7F);
        restarted   = 1'b0;
        ce          = 1'b1;
        blank_start = 1'b1;
        step();
        j  = 0;
        ev = 16'({bl[7], 1'b1, 1'b0});
        chk("blank j=0", blank_obs(), ev);
        while (j < 8) begin
            if ($urandom_range(3) == 0) begin
                ce          = 1'b0;
                blank_start = 1'($urandom_range(1));
                step();
                chk($sformatf("blank_hold j=%0d", j), blank_obs(), ev);
            end
            ce = 1'b1;
            if (!restarted && j == restart_at) begin
                blank_start = 1'b1;
                restarted   = 1'b1;
                j           = 0;
            end else begin
                blank_start = 1'b0;
                j++;
            end
            step();
            ev = (j < 8) ? 16'({bl[7-j], j == 0, j == 7}) : 16'(0);
            chk($sformatf("blank j=%0d r=%0d", j, restart_at), blank_obs(), ev);
        end
        blank_start = 1'b0;
    endtask

    task automatic cnt_run(input int repulse_at);
        int pos;
        pos = 0;
        for (int c = 0; c < 12; c++) begin
            cnt_first = (c == 0) || (c == repulse_at);
            ce        = 1'($urandom_range(1));
            step();
            if (cnt_first) pos = 1;
            else if (pos >= 1 && pos <= 7) pos++;
            chk($sformatf("cnt c=%0d r=%0d", c, repulse_at),
                16'({cnt_valid, cnt_last}), 16'({pos >= 1 && pos <= 7, pos == 7}));
        end
        cnt_first = 1'b0;
    endtask

    initial begin
        logic [6:0] m;
        rst_n       = 1'b1;
        start       = 1'b0;
        ce          = 1'b0;
        data_in     = 1'b0;
        blank_start = 1'b0;
        cnt_first   = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_state", all_obs(), 16'b00000_0_0000_1_000_00);
        #10 rst_n = 1'b1;

        // start with ce=0 must not be accepted
        ce    = 1'b0;
        start = 1'b1;
        step();
        ce    = 1'b1;
        start = 1'b0;
        step();
        chk("start_ce0_ignored", enc_obs(), 16'b000001);

        encode(7'h03, 8'hA2, 0);
        ce = 1'b1;
        step();
        chk("idle_after_cw", enc_obs(), 16'b000001);

        encode(7'h01, 8'hD1, 0);
        encode(7'h00, 8'h00, 0);
        encode(7'h02, 8'h73, 0);
        encode(7'h03, 8'hA2, 30);
        for (int n = 0; n < 6; n++) begin
            m = 7'($urandom_range(127));
            encode(m, ref_parity(m), 20);
        end
        ce = 1'b1;
        step();

        blank_run(-1);
        blank_run(3);
        cnt_run(-1);
        cnt_run(3);

        // Asynchronous reset in the middle of a codeword with everything active
        ce      = 1'b1;
        start   = 1'b1;
        data_in = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        cnt_first   = 1'b1;
        blank_start = 1'b1;
        step();
        cnt_first   = 1'b0;
        blank_start = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("reset_mid_codeword", all_obs(), 16'b00000_0_0000_1_000_00);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        encode(7'h03, 8'hA2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
